gate_sweep_ctrl_311: RTL and testbench

//   Self-checking sequencer for the g_311 two-input gate unit. On start it drives
//   a_311/b_311 through 00,01,10,11 and waits SETTLE cycles after each step. It then

---
 rtl/gate_sweep_ctrl_311.sv | 123 ++++++++++++
 tb/tb_gate_sweep_ctrl_311.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl_311.sv
// gate_sweep_ctrl_311: drives a/b through 00,01,10,11 and checks the seven
// outputs of the g_311 gate unit against their truth table after each step.
module gate_sweep_ctrl_311 #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk_311,
    input  logic       rst_311,
    input  logic       start_311,
    output logic       a_311,
    output logic       b_311,
    input  logic       not_311,
    input  logic       or_311,
    input  logic       and_311,
    input  logic       nand_311,
    input  logic       nor_311,
    input  logic       xor_311,
    input  logic       xnor_311,
    output logic       busy_311,
    output logic       done_311,
    output logic       pass_311,
    output logic [3:0] fail_vec_311,
    output logic [6:0] err_mask_311
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] step;
    logic [3:0] cnt;
    logic [6:0] actual;
    logic [6:0] expected;
    logic [6:0] mism;

    // Truth table for the operands currently driven, and per-output mismatch
    always_comb begin
        expected = {~a_311,
                    a_311 | b_311,
                    a_311 & b_311,
                    ~(a_311 & b_311),
                    ~(a_311 | b_311),
                    a_311 ^ b_311,
                    ~(a_311 ^ b_311)};
        actual   = {not_311, or_311, and_311, nand_311,
                    nor_311, xor_311, xnor_311};
        mism     = actual ^ expected;
    end

    // State register
    always_ff @(posedge clk_311) begin
        if (rst_311) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start_311) state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == 4'd0) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (step == 2'd3) ? S_DONE : S_SETTLE;
            S_DONE:   state_nxt = S_IDLE;
        endcase
    end

    // Operand, settle counter and result registers
    always_ff @(posedge clk_311) begin
        if (rst_311) begin
            a_311        <= 1'b0;
            b_311        <= 1'b0;
            step         <= 2'd0;
            cnt          <= 4'd0;
            pass_311     <= 1'b0;
            fail_vec_311 <= 4'd0;
            err_mask_311 <= 7'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_311) begin
                        step         <= 2'd0;
                        a_311        <= 1'b0;
                        b_311        <= 1'b0;
                        cnt          <= CNT_INIT;
                        pass_311     <= 1'b0;
                        fail_vec_311 <= 4'd0;
                        err_mask_311 <= 7'd0;
                    end
                end
                S_SETTLE: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                S_CHECK: begin
                    err_mask_311       <= err_mask_311 | mism;
                    fail_vec_311[step] <= |mism;
                    if (step == 2'd3) begin
                        // final verdict includes this last step's mismatches
                        pass_311 <= ((err_mask_311 | mism) == 7'd0);
                    end else begin
                        step           <= step + 2'd1;
                        {a_311, b_311} <= step + 2'd1;
                        cnt            <= CNT_INIT;
                    end
                end
                S_DONE: begin
                    // operands park at 00 once the sweep completes
                    a_311 <= 1'b0;
                    b_311 <= 1'b0;
                end
            endcase
        end
    end

    assign busy_311 = (state != S_IDLE);
    assign done_311 = (state == S_DONE);

endmodule

// File: tb/tb_gate_sweep_ctrl_311.sv
// tb_gate_sweep_ctrl_311: three sequencers (SETTLE 2, 1, 15) each driving a
// behavioural gate unit with selectable faults; results checked via scoreboard.
module tb_gate_sweep_ctrl_311;

    typedef struct {
        int         lat;
        logic       pass;
        logic [3:0] fv;
        logic [6:0] em;
        bit         vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st   [3];
    logic       a    [3];
    logic       b    [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [3:0] fv   [3];
    logic [6:0] em   [3];
    logic [6:0] g    [3];
    logic [1:0] pipe [3][3];
    int         mode [3];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sbq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // three-cycle delay line on the operands, used by the slow gate model
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            pipe[i][0] <= {a[i], b[i]};
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    function automatic logic [6:0] gates(logic x, logic y);
        return {~x, x | y, x & y, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
    endfunction

    // mode 0 ideal, 1 xor stuck at 0, 2 not = ~b, 3 ideal but 3 cycles late
    function automatic logic [6:0] model(int md, logic x, logic y);
        logic [6:0] r;
        r = gates(x, y);
        if (md == 1) r[1] = 1'b0;
        if (md == 2) r[6] = ~y;
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            g[i] = 7'd0;
            if (mode[i] == 3) g[i] = gates(pipe[i][2][1], pipe[i][2][0]);
            else              g[i] = model(mode[i], a[i], b[i]);
        end
    end

    gate_sweep_ctrl_311 #(.SETTLE(2)) u_dut0 (
        .clk_311(clk), .rst_311(rst), .start_311(st[0]),
        .a_311(a[0]), .b_311(b[0]),
        .not_311(g[0][6]), .or_311(g[0][5]), .and_311(g[0][4]),
        .nand_311(g[0][3]), .nor_311(g[0][2]), .xor_311(g[0][1]),
        .xnor_311(g[0][0]),
        .busy_311(busy[0]), .done_311(done[0]), .pass_311(pass[0]),
        .fail_vec_311(fv[0]), .err_mask_311(em[0])
    );

    gate_sweep_ctrl_311 #(.SETTLE(1)) u_dut1 (
        .clk_311(clk), .rst_311(rst), .start_311(st[1]),
        .a_311(a[1]), .b_311(b[1]),
        .not_311(g[1][6]), .or_311(g[1][5]), .and_311(g[1][4]),
        .nand_311(g[1][3]), .nor_311(g[1][2]), .xor_311(g[1][1]),
        .xnor_311(g[1][0]),
        .busy_311(busy[1]), .done_311(done[1]), .pass_311(pass[1]),
        .fail_vec_311(fv[1]), .err_mask_311(em[1])
    );

    gate_sweep_ctrl_311 #(.SETTLE(15)) u_dut2 (
        .clk_311(clk), .rst_311(rst), .start_311(st[2]),
        .a_311(a[2]), .b_311(b[2]),
        .not_311(g[2][6]), .or_311(g[2][5]), .and_311(g[2][4]),
        .nand_311(g[2][3]), .nor_311(g[2][2]), .xor_311(g[2][1]),
        .xnor_311(g[2][0]),
        .busy_311(busy[2]), .done_311(done[2]), .pass_311(pass[2]),
        .fail_vec_311(fv[2]), .err_mask_311(em[2])
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic exp_t predict(int md, int settle);
        exp_t       e;
        logic [6:0] m;
        e.lat  = 4 * (settle + 1);
        e.fv   = 4'd0;
        e.em   = 7'd0;
        e.vec  = 1'b1;
        if (md == 3) begin
            e.pass = (settle >= 3);
            e.vec  = e.pass;
        end else begin
            for (int s = 0; s < 4; s++) begin
                m = model(md, s[1], s[0]) ^ gates(s[1], s[0]);
                e.fv[s] = |m;
                e.em    = e.em | m;
            end
            e.pass = (e.em == 7'd0);
        end
        return e;
    endfunction

    task automatic run(int i, int md, int settle);
        exp_t e;
        int   e0;
        bit   seen;
        mode[i] = md;
        sbq.push_back(predict(md, settle));
        @(negedge clk);
        st[i] = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        st[i] = 1'b0;
        chk("busy_rise", 32'(busy[i]), 1);
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (done[i]) seen = 1;
            else @(negedge clk);
        end
        e = sbq.pop_front();
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("latency", 32'(cyc - e0), 32'(e.lat));
            chk("pass", 32'(pass[i]), 32'(e.pass));
            if (e.vec) begin
                chk("fail_vec", 32'(fv[i]), 32'(e.fv));
                chk("err_mask", 32'(em[i]), 32'(e.em));
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done[i]), 0);
        chk("idle_busy", 32'(busy[i]), 0);
        chk("idle_ab", 32'({a[i], b[i]}), 0);
        chk("hold_pass", 32'(pass[i]), 32'(e.pass));
        if (e.vec) chk("hold_fv", 32'(fv[i]), 32'(e.fv));
    endtask

    initial begin
        exp_t e;
        int   e0;
        int   nd;
        for (int i = 0; i < 3; i++) begin
            st[i]   = 1'b0;
            mode[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ab", 32'({a[i], b[i]}), 0);
            chk("rst_flags", 32'({busy[i], done[i], pass[i]}), 0);
            chk("rst_vec", 32'({fv[i], em[i]}), 0);
        end
        rst = 1'b0;

        // ideal, xor stuck at 0, not wired to ~b
        run(0, 0, 2);
        run(0, 1, 2);
        run(0, 2, 2);

        // reset during step 2 settle window aborts the sweep
        mode[0] = 1;
        @(negedge clk);
        st[0] = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_ab", 32'({a[0], b[0]}), 32'd2);
        chk("mid_busy", 32'(busy[0]), 1);
        chk("mid_fv", 32'(fv[0]), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ab", 32'({a[0], b[0]}), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_fv", 32'(fv[0]), 0);
        chk("abort_pass", 32'(pass[0]), 0);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done[0]) nd++;
        end
        chk("abort_nodone", 32'(nd), 0);
        chk("abort_stay_idle", 32'(busy[0]), 0);

        run(0, 0, 2);

        // start held for 30 cycles at SETTLE=1: back-to-back sweeps
        mode[1] = 0;
        for (int k = 0; k < 3; k++) begin
            e = predict(0, 1);
            e.lat = 8 + 10 * k;
            sbq.push_back(e);
        end
        @(negedge clk);
        st[1] = 1'b1;
        e0 = cyc + 1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 29) st[1] = 1'b0;
            if (k == 3) chk("hold_busy", 32'(busy[1]), 1);
            if (done[1]) begin
                nd++;
                if (sbq.size() == 0) begin
                    chk("hold_extra_done", 32'(cyc - e0), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("hold_lat", 32'(cyc - e0), 32'(e.lat));
                    chk("hold_sweep_pass", 32'(pass[1]), 32'(e.pass));
                end
            end
        end
        chk("hold_ndone", 32'(nd), 3);
        chk("hold_sb_empty", 32'(sbq.size()), 0);
        chk("hold_end_idle", 32'(busy[1]), 0);
        sbq.delete();

        // slow gate unit: long settle passes, short settle fails
        run(2, 3, 15);
        run(1, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
